// File: rtl/mem_bus_responder_if.sv
// CPU-side request/response bundle of the memory bus responder.
// master: requester (drives req_*), slave: responder (drives resp_*, busy).
interface mem_bus_responder_if;
   logic [15:0] req_addr;
   logic        req_rd;
   logic        req_wr;
   logic [7:0]  req_wdata;
   logic [7:0]  resp_rdata;
   logic        resp_ready;
   logic        busy;

   modport master (
      output req_addr, req_rd, req_wr, req_wdata,
      input  resp_rdata, resp_ready, busy
   );

   modport slave (
      input  req_addr, req_rd, req_wr, req_wdata,
      output resp_rdata, resp_ready, busy
   );
endinterface

// File: rtl/mem_bus_responder.sv
// GameBoy memory bus responder: HRAM/IE served locally, rest forwarded.
// Ports: clk, rst_n, bus (slave), ext_* port, ie_reg, timeout_err.
// Macro GB_ECHO_RAM_EN: forward E000-FDFF as C000-DDFF when defined.
module mem_bus_responder #(
   parameter int         EXT_TIMEOUT = 15,
   parameter logic [7:0] HRAM_INIT   = 8'h00
) (
   input  logic                      clk,
   input  logic                      rst_n,
   mem_bus_responder_if.slave        bus,
   output logic [15:0]               ext_addr,
   output logic                      ext_rd,
   output logic                      ext_wr,
   output logic [7:0]                ext_wdata,
   input  logic [7:0]                ext_rdata,
   input  logic                      ext_ack,
   output logic [7:0]                ie_reg,
   output logic                      timeout_err
);

   typedef enum logic [1:0] {IDLE, EXT, DONE} state_t;

   localparam logic [7:0] TMO_LAST = 8'(EXT_TIMEOUT - 1);

   state_t      state, state_nx;
   logic [7:0]  hram [0:126];
   logic [7:0]  rdata_q;
   logic [7:0]  wait_cnt;
   logic [15:0] addr;
   logic [6:0]  hidx;
   logic        acc_wr, acc_rd, acc_any;
   logic        is_hram, is_ie, is_dead, is_ext, is_echo;
   logic [15:0] fwd_addr;
   logic        tmo_hit;

   assign addr    = bus.req_addr;
   assign hidx    = addr[6:0];
   // both strobes high is a write
   assign acc_wr  = bus.req_wr;
   assign acc_rd  = bus.req_rd & ~bus.req_wr;
   assign acc_any = bus.req_rd | bus.req_wr;

   assign is_echo = (addr >= 16'hE000) && (addr <= 16'hFDFF);
   assign is_ie   = (addr == 16'hFFFF);
   assign is_hram = (addr >= 16'hFF80) && !is_ie;

`ifdef GB_ECHO_RAM_EN
   assign is_dead  = (addr >= 16'hFEA0) && (addr <= 16'hFEFF);
   assign fwd_addr = is_echo ? addr - 16'h2000 : addr;
`else
   assign is_dead  = ((addr >= 16'hFEA0) && (addr <= 16'hFEFF))
                     || is_echo;
   assign fwd_addr = addr;
`endif

   assign is_ext  = !(is_hram || is_ie || is_dead);
   assign tmo_hit = (wait_cnt == TMO_LAST);

   assign bus.resp_rdata = rdata_q;
   assign bus.resp_ready = (state == DONE);
   assign bus.busy       = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (acc_any) state_nx = is_ext ? EXT : DONE;
         EXT:  if (ext_ack || tmo_hit) state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q     <= 8'h00;
         ext_addr    <= 16'h0000;
         ext_rd      <= 1'b0;
         ext_wr      <= 1'b0;
         ext_wdata   <= 8'h00;
         wait_cnt    <= 8'h00;
         ie_reg      <= 8'h00;
         timeout_err <= 1'b0;
         for (int i = 0; i < 127; i++) hram[i] <= HRAM_INIT;
      end else begin
         case (state)
            IDLE: begin
               if (acc_any) begin
                  if (is_ext) begin
                     ext_addr  <= fwd_addr;
                     ext_wdata <= bus.req_wdata;
                     ext_rd    <= acc_rd;
                     ext_wr    <= acc_wr;
                     wait_cnt  <= 8'h00;
                  end else if (acc_wr) begin
                     if (is_ie)        ie_reg     <= bus.req_wdata;
                     else if (is_hram) hram[hidx] <= bus.req_wdata;
                  end else begin
                     if (is_ie)        rdata_q <= ie_reg;
                     else if (is_hram) rdata_q <= hram[hidx];
                     else              rdata_q <= 8'hFF;
                  end
               end
            end
            EXT: begin
               // an ack in the final wait cycle beats the timeout
               if (ext_ack) begin
                  ext_rd <= 1'b0;
                  ext_wr <= 1'b0;
                  if (ext_rd) rdata_q <= ext_rdata;
               end else if (tmo_hit) begin
                  ext_rd      <= 1'b0;
                  ext_wr      <= 1'b0;
                  rdata_q     <= 8'hFF;
                  timeout_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized bench for mem_bus_responder against a transaction-level model.
// Honours GB_ECHO_RAM_EN the same way the design does.
module tb_mem_bus_responder;

   localparam int TMO = 15;
   localparam logic [7:0] HINIT = 8'h00;

   logic        clk;
   logic        rst_n;
   logic [15:0] ext_addr;
   logic        ext_rd, ext_wr;
   logic [7:0]  ext_wdata;
   logic [7:0]  ext_rdata;
   logic        ext_ack;
   logic [7:0]  ie_reg;
   logic        timeout_err;

   mem_bus_responder_if bus ();

   mem_bus_responder #(
      .EXT_TIMEOUT (TMO),
      .HRAM_INIT   (HINIT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .ext_addr    (ext_addr),
      .ext_rd      (ext_rd),
      .ext_wr      (ext_wr),
      .ext_wdata   (ext_wdata),
      .ext_rdata   (ext_rdata),
      .ext_ack     (ext_ack),
      .ie_reg      (ie_reg),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [7:0] hram_m [0:126];
   logic [7:0] ie_m;
   logic       terr_m;
   logic [7:0] last_m;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 127; i++) hram_m[i] = HINIT;
      ie_m   = 8'h00;
      terr_m = 1'b0;
      last_m = 8'h00;
   endtask

   // 0 hram, 1 ie, 2 unusable, 3 external
   function automatic int classify(input logic [15:0] a,
                                   output logic [15:0] ma);
      int u;
      u  = int'(a);
      ma = a;
      if (u == 'hFFFF) return 1;
      if (u >= 'hFF80) return 0;
      if (u >= 'hFEA0 && u <= 'hFEFF) return 2;
      if (u >= 'hE000 && u <= 'hFDFF) begin
`ifdef GB_ECHO_RAM_EN
         ma = 16'(u - 'h2000);
         return 3;
`else
         return 2;
`endif
      end
      return 3;
   endfunction

   task automatic txn(input logic [15:0] a, input bit w, input bit r,
                      input logic [7:0] wd, input int waits,
                      input logic [7:0] xrd);
      int          kind, exp_lat, lat;
      logic [15:0] ma;
      logic [7:0]  exp_rd;
      bit          tmo, sbad, bbad;
      logic [6:0]  hi;
      kind    = classify(a, ma);
      hi      = a[6:0];
      tmo     = (kind == 3) && (waits >= TMO);
      exp_lat = (kind != 3) ? 1 : (tmo ? TMO + 1 : waits + 2);
      exp_rd  = last_m;
      case (kind)
         0: if (w) hram_m[hi] = wd; else exp_rd = hram_m[hi];
         1: if (w) ie_m = wd; else exp_rd = ie_m;
         2: if (!w) exp_rd = 8'hFF;
         default: begin
            if (tmo) begin
               exp_rd = 8'hFF;
               terr_m = 1'b1;
            end else if (!w) exp_rd = xrd;
         end
      endcase
      last_m = exp_rd;

      bus.req_addr  = a;
      bus.req_rd    = r;
      bus.req_wr    = w;
      bus.req_wdata = wd;
      @(posedge clk); #1;
      bus.req_rd    = 1'b0;
      bus.req_wr    = 1'b0;
      bus.req_addr  = 16'($urandom);
      bus.req_wdata = 8'($urandom);

      lat  = 0;
      sbad = 0;
      bbad = 0;
      for (int c = 1; c <= 40; c++) begin
         if (kind == 3 && c == 1) begin
            chk("ext_addr", ext_addr, ma);
            chk("ext_rd", ext_rd, !w);
            chk("ext_wr", ext_wr, w);
            if (w) chk("ext_wdata", ext_wdata, wd);
         end
         if (kind == 3 && c < exp_lat) begin
            if ((ext_rd | ext_wr) !== 1'b1) sbad = 1;
            if (ext_addr !== ma) sbad = 1;
         end else if ((ext_rd | ext_wr) !== 1'b0) sbad = 1;
         if (bus.busy !== 1'b1) bbad = 1;
         ext_ack   = (kind == 3) && !tmo && (c == waits + 1);
         ext_rdata = ext_ack ? xrd : 8'($urandom);
         if (bus.resp_ready === 1'b1) begin
            lat = c;
            break;
         end
         @(posedge clk); #1;
      end
      ext_ack = 1'b0;
      chk("latency", lat, exp_lat);
      chk("strobes", sbad, 0);
      chk("busy", bbad, 0);
      chk("rdata", bus.resp_rdata, exp_rd);
      chk("tmo_err", timeout_err, terr_m);
      chk("ie_reg", ie_reg, ie_m);
      @(posedge clk); #1;
      chk("pulse_1cyc", bus.resp_ready, 0);
      chk("idle", bus.busy, 0);
      chk("rdata_hold", bus.resp_rdata, exp_rd);
   endtask

   initial begin
      bit seen;
      rst_n         = 1'b0;
      bus.req_addr  = 16'h0000;
      bus.req_rd    = 1'b0;
      bus.req_wr    = 1'b0;
      bus.req_wdata = 8'h00;
      ext_ack       = 1'b0;
      ext_rdata     = 8'h00;
      model_reset();
      #1;
      chk("rst_ready", bus.resp_ready, 0);
      chk("rst_rdata", bus.resp_rdata, 8'h00);
      chk("rst_busy", bus.busy, 0);
      chk("rst_ext_rd", ext_rd, 0);
      chk("rst_ext_wr", ext_wr, 0);
      chk("rst_ext_addr", ext_addr, 16'h0000);
      chk("rst_ext_wdata", ext_wdata, 8'h00);
      chk("rst_ie", ie_reg, 8'h00);
      chk("rst_terr", timeout_err, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      txn(16'hFF80, 1, 0, 8'hA5, 0, 8'h00);
      txn(16'hFF80, 0, 1, 8'h00, 0, 8'h00);
      txn(16'hFFFF, 1, 0, 8'h1F, 0, 8'h00);
      txn(16'hFFFF, 0, 1, 8'h00, 0, 8'h00);
      txn(16'h0150, 0, 1, 8'h00, 3, 8'hC3);
      txn(16'hC000, 1, 0, 8'h77, 99, 8'h00);
      txn(16'hE010, 0, 1, 8'h00, 2, 8'h5A);
      txn(16'hFEA0, 0, 1, 8'h00, 0, 8'h00);
      txn(16'hFEFF, 1, 0, 8'h12, 0, 8'h00);
      txn(16'hFE9F, 0, 1, 8'h00, 0, 8'h3C);
      txn(16'hFF7F, 0, 1, 8'h00, TMO - 1, 8'h96);
      txn(16'hFFFE, 1, 0, 8'h4B, 0, 8'h00);
      txn(16'hFFFE, 0, 1, 8'h00, 0, 8'h00);
      txn(16'hFF81, 1, 1, 8'hE7, 0, 8'h00);
      txn(16'hFF81, 0, 1, 8'h00, 0, 8'h00);
      txn(16'hFDFF, 0, 1, 8'h00, 1, 8'h21);

      // reset two cycles into an external read
      bus.req_addr = 16'h0150;
      bus.req_rd   = 1'b1;
      @(posedge clk); #1;
      bus.req_rd = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ext_rd", ext_rd, 0);
      chk("mid_rst_ie", ie_reg, 8'h00);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_terr", timeout_err, 0);
      seen = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (bus.resp_ready === 1'b1) seen = 1;
      end
      rst_n = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         if (bus.resp_ready === 1'b1) seen = 1;
      end
      chk("mid_rst_no_pulse", seen, 0);
      chk("mid_rst_idle", bus.busy, 0);
      model_reset();
      txn(16'hFF80, 0, 1, 8'h00, 0, 8'h00);

      for (int n = 0; n < 300; n++) begin
         logic [15:0] a;
         bit          r, w;
         int          wt;
         case ($urandom_range(0, 4))
            0: a = 16'hFF80 + 16'($urandom_range(0, 126));
            1: a = 16'hFFFF;
            2: a = 16'hFEA0 + 16'($urandom_range(0, 95));
            3: a = 16'hE000 + 16'($urandom_range(0, 'h1DFF));
            default: a = ($urandom_range(0, 3) == 0)
                         ? 16'hFF00 + 16'($urandom_range(0, 127))
                         : 16'($urandom_range(0, 'hDFFF));
         endcase
         r = 1'($urandom);
         w = 1'($urandom);
         if (!r && !w) r = 1'b1;
         wt = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 20)
                                          : $urandom_range(0, 5);
         txn(a, w, r, 8'($urandom), wt, 8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Responder end of the CPU memory bus. The control path drives read/write requests; this block decodes the GameBoy address map and returns read data plus a completion pulse.
- Serves HRAM (FF80-FFFE) and the IE register (FFFF) internally.
- Forwards cartridge, VRAM, WRAM, OAM and IO accesses to an external memory port that may insert wait states.
- Sits between the datapath memory interface and the system memory/peripheral fabric.

Parameters:
- EXT_TIMEOUT, 15: max cycles spent waiting for ext_ack before abandoning the access; range 1-255.
- HRAM_INIT, 8'h00: reset value of every HRAM byte.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_addr  in  16  CPU byte address.
- req_rd  in  1  read request.
- req_wr  in  1  write request.
- req_wdata  in  8  write data.
- resp_rdata  out  8  read data; valid while resp_ready=1.
- resp_ready  out  1  one-cycle completion pulse.
- busy  out  1  high whenever the FSM is not in IDLE.
- ext_addr  out  16  forwarded address; echo-remapped when the optional feature is on.
- ext_rd  out  1  external read strobe.
- ext_wr  out  1  external write strobe.
- ext_wdata  out  8  external write data.
- ext_rdata  in  8  external read data; valid with ext_ack.
- ext_ack  in  1  external completion.
- ie_reg  out  8  interrupt-enable register (FFFF).
- timeout_err  out  1  sticky flag; set on any external timeout, cleared only by reset.

Behaviour:
Reset (rst_n=0, takes effect immediately):
- FSM=IDLE; resp_ready=0; resp_rdata=8'h00; busy=0.
- ext_rd=0; ext_wr=0; ext_addr=16'h0000; ext_wdata=8'h00.
- ie_reg=8'h00; timeout_err=0; all HRAM bytes=HRAM_INIT.

FSM states: IDLE, EXT, DONE.

IDLE:
- Samples req_rd/req_wr every cycle.
- Both high: treat as a write; a read is not performed.
- Latches req_addr and req_wdata on acceptance.
- Internal target (HRAM, IE, unusable FEA0-FEFF) -> DONE. The access completes on the accept edge:
  - write: stored;
  - read: resp_rdata loaded.
- External target -> EXT. ext_rd or ext_wr goes high on the accept edge, together with ext_addr and ext_wdata. Wait counter is cleared to 0.
- No request -> stay in IDLE.

EXT:
- Strobes held constant.
- Counter increments each cycle ext_ack=0.
- ext_ack=1: strobes drop; for a read, resp_rdata<=ext_rdata; -> DONE.
- Counter reaches EXT_TIMEOUT with no ack: strobes drop; resp_rdata<=8'hFF; timeout_err<=1; write is discarded; -> DONE.
- ext_ack and the timeout in the same cycle: the ack wins.

DONE:
- resp_ready=1 for exactly one cycle, then -> IDLE unconditionally.
- Requests are ignored in DONE. The requester must drop req_rd/req_wr in the cycle resp_ready is high. A request held into IDLE is treated as a new access.

Latency (accept edge to resp_ready high):
- internal: 1 cycle;
- external: ack cycle + 1;
- minimum request-to-request spacing: 2 cycles.

Region rules:
- FEA0-FEFF: reads return 8'hFF; writes are dropped; no external strobe.
- FFFF: ie_reg is fully read/write.
- HRAM: 127 bytes, indexed by req_addr[6:0] over FF80-FFFE.
- resp_rdata holds its last value outside DONE. After a write, resp_rdata is unchanged.
- If rst_n falls mid-EXT, strobes drop immediately and no resp_ready is issued.

Optional Feature:
- Macro: GB_ECHO_RAM_EN.
- Defined: E000-FDFF is forwarded externally with ext_addr = req_addr - 16'h2000, giving C000-DDFF.
- Undefined: E000-FDFF is handled internally like the unusable region. Reads return 8'hFF, writes are dropped, 1-cycle latency, no external strobe.

Test Plan:
- HRAM round trip: write 8'hA5 to FF80, then read FF80 -> resp_ready 1 cycle after each accept; read returns 8'hA5; ext_rd/ext_wr never assert.
- IE register: write 8'h1F to FFFF -> ie_reg=8'h1F on the cycle after accept; a read of FFFF returns 8'h1F.
- External read with 3 wait cycles to 0x0150 (ext_ack on the 4th EXT cycle, ext_rdata=8'hC3):
  - ext_addr=0150 and ext_rd are held for 4 cycles;
  - resp_ready occurs the next cycle with resp_rdata=8'hC3.
- Timeout: external write to C000 with ext_ack tied 0 and EXT_TIMEOUT=15 -> ext_wr drops after 15 EXT cycles; resp_ready=1; timeout_err=1 and stays set.
- Echo region: read E010 with the macro defined -> ext_addr=C010. With the macro undefined -> resp_rdata=8'hFF, 1-cycle latency, no strobe.
- Reset mid-access: drop rst_n 2 cycles into an EXT read -> ext_rd=0 and ie_reg=0 immediately; no resp_ready pulse; FSM is IDLE after release.
